id_ex_pipe_reg: RTL and testbench
=================================

# id_ex_pipe_reg

Pipeline register between the Decode (ID) and Execute (EX) stages of the Osiris I core. It captures the control bundle produced by the op decoder, plus the register-file operands, PC values, immediate and register addresses. It applies hazard-unit stall (hold) and flush (bubble) commands. It optionally sequences a fixed-length FENCE drain window, during which it emits bubbles and asks the hazard unit to freeze IF/ID.

## Interface
Parameters:
- DATA_WIDTH, 32, width of operand, PC and immediate fields
- DRAIN_CYCLES, 4, length of the FENCE drain window in cycles; legal range 1..15

Ports (name, direction, width, meaning):
- i_clk  in  1  core clock, all state updates on its rising edge
- i_rst_n  in  1  asynchronous active-low reset
- i_stall_EX  in  1  hold all register contents
- i_flush_EX  in  1  load a bubble
- i_valid_ID  in  1  ID slot holds a real instruction
- i_ctrl_ID  in  16  control bundle (layout below)
- i_rd1_ID  in  DATA_WIDTH  rs1 read data
- i_rd2_ID  in  DATA_WIDTH  rs2 read data
- i_pc_ID  in  DATA_WIDTH  instruction PC
- i_imm_ext_ID  in  DATA_WIDTH  sign-extended immediate
- i_pc_plus4_ID  in  DATA_WIDTH  PC+4
- i_reg_addr_ID  in  15  {rs1[4:0], rs2[4:0], rd[4:0]}
- o_valid_EX  out  1  EX slot holds a real instruction
- o_ctrl_EX  out  16  registered control bundle
- o_rd1_EX, o_rd2_EX, o_pc_EX, o_imm_ext_EX, o_pc_plus4_EX  out  DATA_WIDTH each  registered data fields
- o_reg_addr_EX  out  15  registered register addresses
- o_fence_busy  out  1  drain window active; the hazard unit must stall IF/ID

Control bundle layout, bit 15 down to bit 0: jump, branch, reg_write, result_src[1:0], mem_write, alu_src, alu_op[2:0], addr_src, fence, funct_3[2:0], funct_7_5.

## Operation
- All outputs reset to 0; FSM resets to IDLE; drain counter resets to 0.
- Each cycle, the next register content is chosen in this priority order: flush > drain bubble > stall > capture.
- Flush: o_valid_EX and all o_ctrl_EX bits go to 0. Data fields and o_reg_addr_EX go to 0. A bubble therefore never writes the register file or memory, and never branches.
- Stall (no flush, FSM IDLE): every register holds its current value.
- Capture: all fields load from their ID inputs. o_valid_EX loads i_valid_ID. When i_valid_ID=0, the control bits load as 0 and the data fields are still captured.
- FSM states and transitions:
  - IDLE → DRAIN on a capture where i_valid_ID=1 and i_ctrl_ID fence bit=1. The counter loads DRAIN_CYCLES. The FENCE itself is captured normally.
  - DRAIN: o_fence_busy=1. Each cycle the register loads a bubble and the counter decrements. i_stall_EX is ignored.
  - DRAIN → IDLE when the counter reaches 1 and decrements to 0. The next cycle resumes normal operation.
  - Flush in either state forces IDLE and clears the counter.
- o_fence_busy is registered: it equals (state==DRAIN).
- A FENCE presented while i_stall_EX=1 is not captured and does not start a drain.

## Timing
- ID→EX latency is 1 cycle. All outputs are registered, with no combinational path from inputs to outputs.
- The FENCE appears at EX in cycle N+1. o_fence_busy is high for cycles N+1 .. N+DRAIN_CYCLES, and bubbles occupy EX in cycles N+2 .. N+DRAIN_CYCLES+1.
- Simultaneous flush and stall: flush wins.
- Simultaneous flush and FENCE capture: a bubble loads and no drain starts.
- Reset asserted mid-drain: outputs, FSM and counter clear immediately (asynchronous). Release is clean, with no partial window.
- Counter width is 4 bits, with no wrap-around; the decrement is gated in IDLE.

## Configuration
- FENCE_DRAIN_EN defined: the FSM, counter and drain behaviour exist as specified above.
- FENCE_DRAIN_EN undefined: no FSM and no counter. o_fence_busy is tied to 0, and a FENCE is captured and passed through like any other instruction.

## Test plan
- Reset: hold i_rst_n=0 with random inputs → all outputs 0. After release, capture ctrl=16'hA5C3, rd1=32'h1234_5678 → both appear on EX one cycle later with o_valid_EX=1.
- Stall: capture pc=0x100, then assert i_stall_EX for 3 cycles while i_pc_ID=0x104 → o_pc_EX stays 0x100 for all 3 cycles and becomes 0x104 one cycle after stall drops.
- Flush vs stall: assert both with reg_write=1 in EX → the next cycle gives o_valid_EX=0, o_ctrl_EX=0 and all data fields 0.
- FENCE drain (macro on, DRAIN_CYCLES=4): capture a FENCE at cycle N → o_fence_busy is high for cycles N+1..N+4, EX holds bubbles in N+2..N+5, and the next instruction is captured at the N+5 edge.
- Flush mid-drain: assert i_flush_EX in the second drain cycle → o_fence_busy=0 the next cycle, and the next non-stalled capture proceeds normally.
- Macro off: capture a FENCE → o_ctrl_EX bit 4=1, o_fence_busy stays 0, and the next instruction follows one cycle later.

Source files
------------

// File: rtl/id_ex_pipe_reg.sv
// id_ex_pipe_reg: ID->EX pipeline register with stall/flush and an optional FENCE drain window.
// Define FENCE_DRAIN_EN to build the drain FSM; otherwise a FENCE passes through like any instruction.
module id_ex_pipe_reg #(
    parameter int DATA_WIDTH   = 32,
    parameter int DRAIN_CYCLES = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_stall_EX,
    input  logic                  i_flush_EX,
    input  logic                  i_valid_ID,
    input  logic [15:0]           i_ctrl_ID,
    input  logic [DATA_WIDTH-1:0] i_rd1_ID,
    input  logic [DATA_WIDTH-1:0] i_rd2_ID,
    input  logic [DATA_WIDTH-1:0] i_pc_ID,
    input  logic [DATA_WIDTH-1:0] i_imm_ext_ID,
    input  logic [DATA_WIDTH-1:0] i_pc_plus4_ID,
    input  logic [14:0]           i_reg_addr_ID,
    output logic                  o_valid_EX,
    output logic [15:0]           o_ctrl_EX,
    output logic [DATA_WIDTH-1:0] o_rd1_EX,
    output logic [DATA_WIDTH-1:0] o_rd2_EX,
    output logic [DATA_WIDTH-1:0] o_pc_EX,
    output logic [DATA_WIDTH-1:0] o_imm_ext_EX,
    output logic [DATA_WIDTH-1:0] o_pc_plus4_EX,
    output logic [14:0]           o_reg_addr_EX,
    output logic                  o_fence_busy
);
    logic                  valid_q, valid_d;
    logic [15:0]           ctrl_q, ctrl_d;
    logic [DATA_WIDTH-1:0] rd1_q, rd1_d, rd2_q, rd2_d, pc_q, pc_d;
    logic [DATA_WIDTH-1:0] imm_q, imm_d, pc4_q, pc4_d;
    logic [14:0]           ra_q, ra_d;
    logic                  drain_active, bubble, hold;

`ifdef FENCE_DRAIN_EN
    typedef enum logic {IDLE, DRAIN} state_e;
    state_e     state_q;
    logic [3:0] cnt_q;

    assign drain_active = (state_q == DRAIN);
    assign o_fence_busy = drain_active;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
        end else if (i_flush_EX) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
        end else if (state_q == DRAIN) begin
            cnt_q <= cnt_q - 4'd1;
            if (cnt_q == 4'd1) state_q <= IDLE;
        end else if (!i_stall_EX && i_valid_ID && i_ctrl_ID[4]) begin
            state_q <= DRAIN;
            cnt_q   <= 4'(DRAIN_CYCLES);
        end
    end
`else
    assign drain_active = 1'b0;
    assign o_fence_busy = 1'b0;
`endif

    // Priority: flush > drain bubble > stall > capture.
    always_comb begin
        bubble  = i_flush_EX | drain_active;
        hold    = i_stall_EX & ~bubble;
        valid_d = bubble ? 1'b0 : hold ? valid_q : i_valid_ID;
        ctrl_d  = bubble ? 16'd0 : hold ? ctrl_q : (i_valid_ID ? i_ctrl_ID : 16'd0);
        rd1_d   = bubble ? '0 : hold ? rd1_q : i_rd1_ID;
        rd2_d   = bubble ? '0 : hold ? rd2_q : i_rd2_ID;
        pc_d    = bubble ? '0 : hold ? pc_q  : i_pc_ID;
        imm_d   = bubble ? '0 : hold ? imm_q : i_imm_ext_ID;
        pc4_d   = bubble ? '0 : hold ? pc4_q : i_pc_plus4_ID;
        ra_d    = bubble ? 15'd0 : hold ? ra_q : i_reg_addr_ID;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            valid_q <= 1'b0;
            ctrl_q  <= 16'd0;
            rd1_q   <= '0;
            rd2_q   <= '0;
            pc_q    <= '0;
            imm_q   <= '0;
            pc4_q   <= '0;
            ra_q    <= 15'd0;
        end else begin
            valid_q <= valid_d;
            ctrl_q  <= ctrl_d;
            rd1_q   <= rd1_d;
            rd2_q   <= rd2_d;
            pc_q    <= pc_d;
            imm_q   <= imm_d;
            pc4_q   <= pc4_d;
            ra_q    <= ra_d;
        end
    end

    assign o_valid_EX    = valid_q;
    assign o_ctrl_EX     = ctrl_q;
    assign o_rd1_EX      = rd1_q;
    assign o_rd2_EX      = rd2_q;
    assign o_pc_EX       = pc_q;
    assign o_imm_ext_EX  = imm_q;
    assign o_pc_plus4_EX = pc4_q;
    assign o_reg_addr_EX = ra_q;
endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// tb_id_ex_pipe_reg: directed and random checks of id_ex_pipe_reg against a cycle-indexed reference model.
// Honors FENCE_DRAIN_EN the same way as the design.
module tb_id_ex_pipe_reg;
    localparam int W = 32;
    localparam int D = 4;
`ifdef FENCE_DRAIN_EN
    localparam bit EN = 1'b1;
`else
    localparam bit EN = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n, stall, flush, valid;
    logic [15:0]   ctrl;
    logic [W-1:0]  rd1, rd2, pc, imm, pc4;
    logic [14:0]   ra;
    logic          o_valid, o_busy;
    logic [15:0]   o_ctrl;
    logic [W-1:0]  o_rd1, o_rd2, o_pc, o_imm, o_pc4;
    logic [14:0]   o_ra;

    id_ex_pipe_reg #(.DATA_WIDTH(W), .DRAIN_CYCLES(D)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_stall_EX(stall), .i_flush_EX(flush),
        .i_valid_ID(valid), .i_ctrl_ID(ctrl), .i_rd1_ID(rd1), .i_rd2_ID(rd2),
        .i_pc_ID(pc), .i_imm_ext_ID(imm), .i_pc_plus4_ID(pc4), .i_reg_addr_ID(ra),
        .o_valid_EX(o_valid), .o_ctrl_EX(o_ctrl), .o_rd1_EX(o_rd1), .o_rd2_EX(o_rd2),
        .o_pc_EX(o_pc), .o_imm_ext_EX(o_imm), .o_pc_plus4_EX(o_pc4),
        .o_reg_addr_EX(o_ra), .o_fence_busy(o_busy)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference model: EX contents plus the edge index at which the last FENCE was captured.
    logic         m_valid, m_busy;
    logic [15:0]  m_ctrl;
    logic [W-1:0] m_rd1, m_rd2, m_pc, m_imm, m_pc4;
    logic [14:0]  m_ra;
    int           edge_n = 0;
    int           fence_edge = -1;

    task automatic model_clear();
        m_valid = 0; m_ctrl = 0; m_rd1 = 0; m_rd2 = 0; m_pc = 0;
        m_imm = 0; m_pc4 = 0; m_ra = 0;
    endtask

    task automatic model_reset();
        model_clear();
        m_busy = 0;
        fence_edge = -1;
    endtask

    task automatic model_edge();
        bit in_drain;
        edge_n++;
        in_drain = EN && fence_edge >= 0 && edge_n > fence_edge && edge_n <= fence_edge + D;
        if (flush) begin
            model_clear();
            fence_edge = -1;
        end else if (in_drain) begin
            model_clear();
        end else if (!stall) begin
            m_valid = valid;
            m_ctrl  = valid ? ctrl : 16'd0;
            m_rd1 = rd1; m_rd2 = rd2; m_pc = pc; m_imm = imm; m_pc4 = pc4; m_ra = ra;
            if (EN && valid && ctrl[4]) fence_edge = edge_n;
        end
        m_busy = EN && fence_edge >= 0 && edge_n >= fence_edge && edge_n < fence_edge + D;
    endtask

    task automatic compare_all();
        check("valid", 64'(o_valid), 64'(m_valid));
        check("ctrl",  64'(o_ctrl),  64'(m_ctrl));
        check("rd1",   64'(o_rd1),   64'(m_rd1));
        check("rd2",   64'(o_rd2),   64'(m_rd2));
        check("pc",    64'(o_pc),    64'(m_pc));
        check("imm",   64'(o_imm),   64'(m_imm));
        check("pc4",   64'(o_pc4),   64'(m_pc4));
        check("ra",    64'(o_ra),    64'(m_ra));
        check("busy",  64'(o_busy),  64'(m_busy));
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic rand_inputs();
        valid = ($urandom_range(0, 3) != 0);
        ctrl  = 16'($urandom) & ~16'h0010;
        if ($urandom_range(0, 5) == 0) ctrl[4] = 1'b1;
        rd1 = $urandom; rd2 = $urandom; pc = $urandom; imm = $urandom; pc4 = $urandom;
        ra  = 15'($urandom);
    endtask

    initial begin
        rst_n = 0; stall = 0; flush = 0;
        rand_inputs();
        model_reset();
        for (int i = 0; i < 3; i++) begin
            rand_inputs();
            stall = 1'($urandom);
            @(posedge clk); #1;
            compare_all();
        end
        rst_n = 1; stall = 0; flush = 0;

        // First capture after reset
        rand_inputs(); valid = 1; ctrl = 16'hA5C3; rd1 = 32'h1234_5678;
        tick();
        check("ctrl_A5C3", 64'(o_ctrl), 64'h A5C3);
        check("rd1_first", 64'(o_rd1), 64'h1234_5678);
        check("valid_first", 64'(o_valid), 64'd1);

        // Stall holds the captured PC
        rand_inputs(); valid = 1; ctrl = 16'h0000; pc = 32'h100;
        tick();
        pc = 32'h104; stall = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("pc_stalled", 64'(o_pc), 64'h100);
        end
        stall = 0;
        tick();
        check("pc_after_stall", 64'(o_pc), 64'h104);

        // Flush beats stall
        rand_inputs(); valid = 1; ctrl = 16'h2000;
        tick();
        stall = 1; flush = 1;
        tick();
        check("flush_valid", 64'(o_valid), 64'd0);
        check("flush_ctrl", 64'(o_ctrl), 64'd0);
        check("flush_rd1", 64'(o_rd1), 64'd0);
        stall = 0; flush = 0;

        // FENCE drain window, then the held instruction is taken
        rand_inputs(); valid = 1; ctrl = 16'h0010;
        tick();
        check("fence_ctrl", 64'(o_ctrl), 64'h0010);
        check("fence_busy", 64'(o_busy), 64'(EN));
        rand_inputs(); valid = 1; ctrl = 16'h2000; pc = 32'h200;
        for (int i = 0; i < D + 1; i++) tick();
        check("post_fence_ctrl", 64'(o_ctrl), 64'h2000);
        check("post_fence_pc", 64'(o_pc), 64'h200);
        check("post_fence_busy", 64'(o_busy), 64'd0);

        // Flush in the second drain cycle
        rand_inputs(); valid = 1; ctrl = 16'h0010;
        tick();
        rand_inputs(); ctrl[4] = 1'b0;
        tick();
        flush = 1;
        tick();
        check("midflush_busy", 64'(o_busy), 64'd0);
        flush = 0; valid = 1; ctrl = 16'h4000;
        tick();
        check("midflush_next", 64'(o_ctrl), 64'h4000);

        // Asynchronous reset in the middle of a drain
        rand_inputs(); valid = 1; ctrl = 16'h0010;
        tick();
        rand_inputs(); ctrl[4] = 1'b0;
        tick();
        #2 rst_n = 0;
        model_reset();
        #1 compare_all();
        #2 rst_n = 1;
        tick();

        // Random traffic
        for (int i = 0; i < 300; i++) begin
            rand_inputs();
            stall = ($urandom_range(0, 4) == 0);
            flush = ($urandom_range(0, 9) == 0);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
